jtag_scan_master: RTL
=====================

# jtag_scan_master

Command-driven JTAG master sequencer that drives the TMS/TDI pins of a 16-state TAP controller and captures TDO. It converts single commands (TAP reset, IR scan, DR scan, idle clocks) into the exact TMS bit streams. It keeps a cycle-accurate mirror of the target TAP state. It sits between the host/test logic and the TAP controller, sharing TCLK with it.

## Interface
- `DATA_W`, 32: maximum scan length in bits; width of command/response data.
- `LEN_W`, 6: width of `cmd_len`; must satisfy 2^LEN_W > DATA_W.
- `TCLK` in 1: JTAG clock; all state updates on posedge.
- `TRST` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: master can accept a command.
- `cmd_op` in 2: operation code.
  - 00 TAP reset.
  - 01 IR scan.
  - 10 DR scan.
  - 11 idle clocks.
- `cmd_len` in LEN_W: bit count for scans, or cycle count for idle.
- `cmd_data` in DATA_W: scan-in data, shifted LSB first.
- `TMS` out 1: registered test-mode-select to the TAP.
- `TDI` out 1: registered test data in.
- `TDO` in 1: test data out from the target.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out DATA_W: captured TDO bits, right-aligned.
- `tap_state` out 4: mirror of the target state, using the TAP 4-bit encoding (0000 Test-Logic-Reset, 0001 Run-Test/Idle, 0100 Shift-DR, 1011 Shift-IR, ...).

## Operation
- FSM states:
  - S_IDLE: `cmd_ready`=1.
  - S_RST: TMS=1 for 5 cycles, then 0.
  - S_PRE: path from Idle to Shift-xR.
  - S_SHIFT: shifting.
  - S_POST: Exit1 → Update → Idle.
  - S_WAIT: idle clocks.
  - S_RSP: `rsp_valid`=1, `cmd_ready`=0; always returns to S_IDLE.
- A command is accepted on a posedge with `cmd_valid` && `cmd_ready`. Inputs are registered at acceptance.
- Mirror update: at each posedge, `tap_state` takes the TAP transition function of (`tap_state`, current `TMS`). It therefore always equals the target state.
- TMS streams, counted from acceptance:
  - Reset: 1,1,1,1,1,0.
  - IR scan: 1,1,0,0 → Shift-IR; then N-1 zeros; then 1 (the last shift bit exits to Exit1-IR); then 1,0.
  - DR scan: 1,0,0 → Shift-DR; then N-1 zeros; then 1; then 1,0.
  - Idle: N zeros.
- If `tap_state` is Test-Logic-Reset when a scan or idle command is accepted, one TMS=0 is prepended to reach Run-Test/Idle.
- Scan length: N = `cmd_len`. N=0 is treated as 1. N>DATA_W is clamped to DATA_W.
- Idle: N=0 is treated as 1.
- TDI carries `cmd_data[i]` stable across the i-th posedge at which the target is in Shift-xR. TDI is 0 otherwise.
- TDO is sampled on those same posedges into `rsp_data[i]`. Bits [DATA_W-1:N] are 0. `rsp_data` holds until the next scan completes.
- When no command is active, TMS holds the target in place: 0 in Run-Test/Idle, 1 in Test-Logic-Reset.
- No back-pressure on the response. `cmd_valid` while busy is ignored, because `cmd_ready` is 0.

## Timing
- Reset values (asynchronous assert, synchronous use after deassert):
  - TMS=1, TDI=0.
  - `tap_state`=0000, FSM=S_IDLE, `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0.
- TMS/TDI change only on posedge TCLK. The target consumes each value at the following posedge.
- Stream length L, excluding any prepended bit:
  - Reset: 6.
  - DR scan: N+5.
  - IR scan: N+6.
  - Idle: N.
- `rsp_valid` rises at acceptance edge + L (+1 if prepended) and lasts one cycle. `tap_state` is 0001 at that edge. `cmd_ready` rises at the following edge.
- Back-to-back: earliest next acceptance is 2 edges after `rsp_valid` rises.
- TRST asserted mid-command: the command is aborted and no `rsp_valid` is issued. The stream restarts only on a new command.

## Configuration
- `JTAG_SCAN_CAPTURE_EN` defined: TDO capture into `rsp_data` as specified.
- Not defined:
  - No capture flops.
  - `rsp_data` is tied to 0.
  - `rsp_valid` remains a pure completion pulse.
  - TDO is unused.
  - All TMS/TDI timing is identical.

## Test plan
- Reset command after TRST: TMS stream 1,1,1,1,1,0, then `tap_state`=0001; `rsp_valid` at acceptance+6.
- DR scan from Test-Logic-Reset: N=8, `cmd_data`=0xA5, target TDO looped from TDI.
  - TMS stream: prepended 0, then 1,0,0,0×7,1,1,0.
  - TDI bits 1,0,1,0,0,1,0,1; `rsp_data`=0x000000A5; `rsp_valid` at acceptance+14.
- IR scan from Idle: N=4, `cmd_data`=0xE, TDO tied 1.
  - `tap_state` passes 1001, 1010, then 1011 ×4, then 1100, 1111, 0001.
  - `rsp_data`=0x0000000F.
- Lengths: DR `cmd_len`=0 shifts exactly 1 bit; `cmd_len`=40 (DATA_W=32) shifts 32 bits; idle `cmd_len`=3 gives TMS=0 for 3 cycles, `rsp_valid` at +3.
- Protocol: `cmd_valid` held high with changing data during a DR scan → ignored; the next command is accepted 2 edges after `rsp_valid`.
- TRST pulsed low in the middle of Shift-DR: outputs go to reset values immediately, no `rsp_valid`, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/jtag_scan_master.sv
// Command-driven JTAG sequencer: turns reset/IR/DR/idle commands into TMS/TDI streams and mirrors the TAP state.
// Define JTAG_SCAN_CAPTURE_EN to capture TDO into rsp_data; otherwise rsp_data is tied to zero.
module jtag_scan_master #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              TCLK,
   input  logic              TRST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              TMS,
   output logic              TDI,
   input  logic              TDO,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        tap_state
);

   localparam logic [1:0] OP_RST  = 2'b00;
   localparam logic [1:0] OP_IR   = 2'b01;
   localparam logic [1:0] OP_DR   = 2'b10;

   localparam logic [3:0] TAP_TLR   = 4'b0000;
   localparam logic [3:0] TAP_RTI   = 4'b0001;
   localparam logic [3:0] TAP_SELDR = 4'b0010;
   localparam logic [3:0] TAP_CAPDR = 4'b0011;
   localparam logic [3:0] TAP_SHDR  = 4'b0100;
   localparam logic [3:0] TAP_EX1DR = 4'b0101;
   localparam logic [3:0] TAP_PSDR  = 4'b0110;
   localparam logic [3:0] TAP_EX2DR = 4'b0111;
   localparam logic [3:0] TAP_UPDR  = 4'b1000;
   localparam logic [3:0] TAP_SELIR = 4'b1001;
   localparam logic [3:0] TAP_CAPIR = 4'b1010;
   localparam logic [3:0] TAP_SHIR  = 4'b1011;
   localparam logic [3:0] TAP_EX1IR = 4'b1100;
   localparam logic [3:0] TAP_PSIR  = 4'b1101;
   localparam logic [3:0] TAP_EX2IR = 4'b1110;
   localparam logic [3:0] TAP_UPIR  = 4'b1111;

   localparam logic [LEN_W:0] CNT_ONE      = 1;
   localparam logic [LEN_W:0] CNT_RST_LAST = 5;
   localparam logic [LEN_W:0] CNT_RST_END  = 6;
   localparam logic [LEN_W:0] LIM_MAX      = (LEN_W+1)'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_PRE, S_SHIFT, S_POST, S_WAIT, S_RSP
   } state_t;

   function automatic logic [3:0] tap_next(input logic [3:0] st, input logic tms);
      logic [3:0] nxt;
      case (st)
         TAP_TLR:   nxt = tms ? TAP_TLR   : TAP_RTI;
         TAP_RTI:   nxt = tms ? TAP_SELDR : TAP_RTI;
         TAP_SELDR: nxt = tms ? TAP_SELIR : TAP_CAPDR;
         TAP_CAPDR: nxt = tms ? TAP_EX1DR : TAP_SHDR;
         TAP_SHDR:  nxt = tms ? TAP_EX1DR : TAP_SHDR;
         TAP_EX1DR: nxt = tms ? TAP_UPDR  : TAP_PSDR;
         TAP_PSDR:  nxt = tms ? TAP_EX2DR : TAP_PSDR;
         TAP_EX2DR: nxt = tms ? TAP_UPDR  : TAP_SHDR;
         TAP_UPDR:  nxt = tms ? TAP_SELDR : TAP_RTI;
         TAP_SELIR: nxt = tms ? TAP_TLR   : TAP_CAPIR;
         TAP_CAPIR: nxt = tms ? TAP_EX1IR : TAP_SHIR;
         TAP_SHIR:  nxt = tms ? TAP_EX1IR : TAP_SHIR;
         TAP_EX1IR: nxt = tms ? TAP_UPIR  : TAP_PSIR;
         TAP_PSIR:  nxt = tms ? TAP_EX2IR : TAP_PSIR;
         TAP_EX2IR: nxt = tms ? TAP_UPIR  : TAP_SHIR;
         default:   nxt = tms ? TAP_SELDR : TAP_RTI;
      endcase
      return nxt;
   endfunction

   // TMS that walks from TLR/Idle toward Capture-xR; Capture itself gets 0 to enter Shift-xR.
   function automatic logic pre_tms(input logic [3:0] st, input logic ir);
      logic t;
      case (st)
         TAP_RTI:   t = 1'b1;
         TAP_SELDR: t = ir;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_tap, w_tap_nxt;
   logic              r_tms, w_tms_nxt;
   logic              r_tdi, w_tdi_nxt;
   logic [LEN_W:0]    r_cnt, w_cnt_nxt;
   logic [LEN_W:0]    r_lim, w_lim_nxt;
   logic              r_ir, w_ir_nxt;
   logic [DATA_W-1:0] r_sh;
   logic              w_accept, w_drive;
   logic [LEN_W:0]    w_scan_n, w_idle_n;

   // The mirror advances with the TMS value the target sees at this edge.
   assign w_tap_nxt = tap_next(r_tap, r_tms);

   assign w_scan_n = (cmd_len == '0) ? CNT_ONE :
                     ({1'b0, cmd_len} > LIM_MAX) ? LIM_MAX : {1'b0, cmd_len};
   assign w_idle_n = ((cmd_len == '0) ? CNT_ONE : {1'b0, cmd_len}) +
                     {{LEN_W{1'b0}}, (r_tap == TAP_TLR)};

   always_comb begin
      w_state_nxt = r_state;
      w_tms_nxt   = (w_tap_nxt == TAP_TLR);
      w_tdi_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_lim_nxt   = r_lim;
      w_ir_nxt    = r_ir;
      w_accept    = 1'b0;
      w_drive     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept  = 1'b1;
               w_cnt_nxt = '0;
               w_ir_nxt  = (cmd_op == OP_IR);
               case (cmd_op)
                  OP_RST: begin
                     w_tms_nxt   = 1'b1;
                     w_cnt_nxt   = CNT_ONE;
                     w_state_nxt = S_RST;
                  end
                  OP_IR, OP_DR: begin
                     w_tms_nxt   = pre_tms(w_tap_nxt, (cmd_op == OP_IR));
                     w_lim_nxt   = w_scan_n;
                     w_state_nxt = S_PRE;
                  end
                  default: begin
                     w_tms_nxt   = 1'b0;
                     w_cnt_nxt   = CNT_ONE;
                     w_lim_nxt   = w_idle_n;
                     w_state_nxt = S_WAIT;
                  end
               endcase
            end
         end
         S_RST: begin
            if (r_cnt == CNT_RST_END) begin
               w_tms_nxt   = 1'b0;
               w_state_nxt = S_RSP;
            end else begin
               w_tms_nxt = (r_cnt != CNT_RST_LAST);
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         S_PRE: begin
            w_tms_nxt = pre_tms(w_tap_nxt, r_ir);
            if ((w_tap_nxt == TAP_CAPDR) || (w_tap_nxt == TAP_CAPIR))
               w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            // Each edge that leaves the target in Shift-xR presents the next data bit.
            if ((w_tap_nxt == TAP_SHDR) || (w_tap_nxt == TAP_SHIR)) begin
               w_drive   = 1'b1;
               w_tdi_nxt = r_sh[0];
               w_tms_nxt = (r_cnt == (r_lim - CNT_ONE));
               w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
               w_tms_nxt   = 1'b1;
               w_state_nxt = S_POST;
            end
         end
         S_POST: begin
            w_tms_nxt = 1'b0;
            if (w_tap_nxt == TAP_RTI)
               w_state_nxt = S_RSP;
         end
         S_WAIT: begin
            w_tms_nxt = 1'b0;
            if (r_cnt == r_lim)
               w_state_nxt = S_RSP;
            else
               w_cnt_nxt = r_cnt + CNT_ONE;
         end
         S_RSP: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST) begin
         r_state <= S_IDLE;
         r_tap   <= TAP_TLR;
         r_tms   <= 1'b1;
         r_tdi   <= 1'b0;
         r_cnt   <= '0;
         r_lim   <= '0;
         r_ir    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tap   <= w_tap_nxt;
         r_tms   <= w_tms_nxt;
         r_tdi   <= w_tdi_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lim   <= w_lim_nxt;
         r_ir    <= w_ir_nxt;
      end
   end

   always_ff @(posedge TCLK) begin
      if (w_accept)
         r_sh <= cmd_data;
      else if (w_drive)
         r_sh <= r_sh >> 1;
   end

`ifdef JTAG_SCAN_CAPTURE_EN
   logic [DATA_W-1:0] r_cap, r_rsp_data;
   logic [LEN_W:0]    w_align;
   logic              w_capture, w_done_scan;

   assign w_capture   = (r_state == S_SHIFT) && ((r_tap == TAP_SHDR) || (r_tap == TAP_SHIR));
   assign w_done_scan = (r_state == S_POST) && (w_tap_nxt == TAP_RTI);
   // Bits enter at the MSB, so after N shifts the scan sits in the top N bits.
   assign w_align     = LIM_MAX - r_lim;

   always_ff @(posedge TCLK) begin
      if (w_capture)
         r_cap <= {TDO, r_cap[DATA_W-1:1]};
   end

   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST)
         r_rsp_data <= '0;
      else if (w_done_scan)
         r_rsp_data <= r_cap >> w_align;
   end

   assign rsp_data = r_rsp_data;
`else
   logic w_unused_tdo;
   assign w_unused_tdo = TDO;
   assign rsp_data     = '0;
`endif

   assign cmd_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RSP);
   assign TMS       = r_tms;
   assign TDI       = r_tdi;
   assign tap_state = r_tap;

endmodule
